cart_upload: RTL and testbench

//  Read-back side of the HPS ioctl file channel: serves ioctl_rd requests during an

---
 rtl/cart_upload_if.sv | 33 +++
 rtl/cart_upload.sv | 123 ++++++++++++
 tb/tb_cart_upload.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cart_upload_if.sv
// Purpose: ioctl upload/download signals plus the cart RAM read port for cart_upload.
// Latency: none, wiring only.
// Backpressure: ioctl_wait stalls the hps_io side; the RAM port takes no backpressure.
// Ports: ioctl_download/upload/wr/rd/addr come from hps_io, ioctl_din/wait go back to it;
//        mem_addr/mem_rd drive the cart RAM and mem_q returns its data; img_size/busy are status.
interface cart_upload_if #(
    parameter int ADDR_W = 15
);
    logic              ioctl_download;
    logic              ioctl_upload;
    logic              ioctl_wr;
    logic              ioctl_rd;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_q;
    logic [ADDR_W:0]   img_size;
    logic              busy;

    // master: hps_io plus cart RAM environment
    modport master (
        output ioctl_download, ioctl_upload, ioctl_wr, ioctl_rd, ioctl_addr, mem_q,
        input  ioctl_din, ioctl_wait, mem_addr, mem_rd, img_size, busy
    );

    // slave: the cart_upload block
    modport slave (
        input  ioctl_download, ioctl_upload, ioctl_wr, ioctl_rd, ioctl_addr, mem_q,
        output ioctl_din, ioctl_wait, mem_addr, mem_rd, img_size, busy
    );
endinterface

// File: rtl/cart_upload.sv
// Purpose: serves hps_io upload reads from cart RAM and tracks the last downloaded image size.
// Latency: in-range read returns 2+RD_LAT cycles after ioctl_rd, out-of-range FILL after 2 cycles.
// Backpressure: ioctl_wait held high while a read is outstanding; ioctl_rd while busy is dropped.
// Ports: clk_sys, reset (sync, active high); bus (slave modport) carries the ioctl handshake,
//        the cart RAM read port (mem_addr/mem_rd/mem_q) and the img_size/busy status.
module cart_upload #(
    parameter int         ADDR_W = 15,
    parameter int         RD_LAT = 2,
    parameter logic [7:0] FILL   = 8'hFF
) (
    input  logic        clk_sys,
    input  logic        reset,
    cart_upload_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, LAT, DONE} state_t;

    localparam logic [ADDR_W:0] MAX_SIZE = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [2:0]      LAT_INIT = 3'(RD_LAT - 1);

    state_t            state;
    logic [2:0]        lat_cnt;
    logic              dl_q;
    logic [ADDR_W:0]   img_size_r;
    logic [7:0]        din_r;
    logic              wait_r;
    logic              mem_rd_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              busy_r;

    logic [ADDR_W:0]   size_base;
    logic [ADDR_W:0]   wr_size;
    logic [ADDR_W:0]   size_next;
    logic              rd_accept;
    logic              in_range;

    // Size tracking: a new download session starts from zero, and every written byte
    // extends the image to cover it. Addresses past the RAM clamp to the full size.
    always_comb begin
        size_base = (bus.ioctl_download && !dl_q) ? '0 : img_size_r;
        if (bus.ioctl_addr >= 25'(MAX_SIZE))
            wr_size = MAX_SIZE;
        else
            wr_size = bus.ioctl_addr[ADDR_W:0] + ONE;
        size_next = size_base;
        if (bus.ioctl_wr && bus.ioctl_download && (wr_size > size_base))
            size_next = wr_size;
    end

    // Download has priority: a read request that overlaps a download is dropped.
    assign rd_accept = bus.ioctl_rd && bus.ioctl_upload && !bus.ioctl_download;
    // Full-width compare so high addresses never alias into the image.
    assign in_range  = bus.ioctl_addr < 25'(img_size_r);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            dl_q       <= 1'b0;
            img_size_r <= '0;
            din_r      <= '0;
            wait_r     <= 1'b0;
            mem_rd_r   <= 1'b0;
            mem_addr_r <= '0;
            busy_r     <= 1'b0;
        end else begin
            dl_q       <= bus.ioctl_download;
            img_size_r <= size_next;
            mem_rd_r   <= 1'b0;

            if (state != IDLE && !bus.ioctl_upload) begin
                // Upload cancelled by the host: release the stall, keep the last byte.
                state  <= IDLE;
                wait_r <= 1'b0;
                busy_r <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rd_accept) begin
                            wait_r <= 1'b1;
                            busy_r <= 1'b1;
                            if (in_range) begin
                                // Strobe is registered here so the RAM sees it during FETCH.
                                mem_rd_r   <= 1'b1;
                                mem_addr_r <= bus.ioctl_addr[ADDR_W-1:0];
                                state      <= FETCH;
                            end else begin
                                din_r <= FILL;
                                state <= DONE;
                            end
                        end
                    end
                    FETCH: begin
                        lat_cnt <= LAT_INIT;
                        state   <= LAT;
                    end
                    LAT: begin
                        if (lat_cnt == 3'd0) begin
                            din_r  <= bus.mem_q;
                            wait_r <= 1'b0;
                            state  <= DONE;
                        end else begin
                            lat_cnt <= lat_cnt - 3'd1;
                        end
                    end
                    DONE: begin
                        wait_r <= 1'b0;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ioctl_din  = din_r;
    assign bus.ioctl_wait = wait_r;
    assign bus.mem_rd     = mem_rd_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.img_size   = img_size_r;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_cart_upload.sv
// Purpose: randomized scoreboard bench for cart_upload with a cart RAM model.
// Latency: expectations carry the stall length each request must show.
// Backpressure: requests are issued only once the previous response has drained.
module tb_cart_upload;
    localparam int         ADDR_W = 15;
    localparam int         RD_LAT = 2;
    localparam logic [7:0] FILL   = 8'hFF;
    localparam int         MAXSZ  = 1 << ADDR_W;

    typedef struct {
        int din;
        int wlen;
        int nrd;
        int addr;
    } exp_t;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    cart_upload_if #(.ADDR_W(ADDR_W)) bus();

    cart_upload #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .FILL(FILL)) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (bus)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    int   model_size;
    int   last_din;

    logic [7:0] ram [MAXSZ];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Cart RAM: data appears RD_LAT cycles after the strobe, zero otherwise.
    logic [7:0] pd [RD_LAT];
    logic       pv [RD_LAT];
    always @(posedge clk_sys) begin
        pd[0] <= ram[bus.mem_addr];
        pv[0] <= bus.mem_rd;
        for (int i = 1; i < RD_LAT; i++) begin
            pd[i] <= pd[i-1];
            pv[i] <= pv[i-1];
        end
    end
    assign bus.mem_q = (pv[RD_LAT-1] === 1'b1) ? pd[RD_LAT-1] : 8'h00;

    // Monitor: a falling ioctl_wait marks a response; compare it to the oldest expectation.
    bit prev_wait = 1'b0;
    int wlen      = 0;
    int rdcnt     = 0;
    always @(negedge clk_sys) begin
        if (bus.mem_rd === 1'b1) begin
            rdcnt++;
            if (q.size() == 0)
                check("mem_rd_spurious", 1, 0);
            else
                check("mem_addr", int'(bus.mem_addr), q[0].addr);
        end
        if (bus.ioctl_wait === 1'b1) begin
            wlen++;
        end else if (prev_wait) begin
            if (q.size() == 0) begin
                check("unexpected_resp", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("din", int'(bus.ioctl_din), e.din);
                check("wait_len", wlen, e.wlen);
                check("mem_rd_count", rdcnt, e.nrd);
            end
            wlen  = 0;
            rdcnt = 0;
        end
        prev_wait = (bus.ioctl_wait === 1'b1);
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) tick();
        check("drain", q.size(), 0);
        q.delete();
        tick();
        tick();
    endtask

    // Reference: in range fetches RAM with a 1+RD_LAT stall, otherwise FILL after one stall cycle.
    function automatic exp_t predict(input int addr);
        exp_t e;
        if (addr < model_size) begin
            e.din = int'(ram[addr]); e.wlen = 1 + RD_LAT; e.nrd = 1; e.addr = addr;
        end else begin
            e.din = int'(FILL); e.wlen = 1; e.nrd = 0; e.addr = 0;
        end
        return e;
    endfunction

    task automatic issue_rd(input int addr, input bit dbl, input int addr2);
        exp_t e;
        e = predict(addr);
        q.push_back(e);
        last_din = e.din;
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = 25'(addr);
        tick();
        bus.ioctl_rd = 1'b0;
        if (dbl) begin
            bus.ioctl_rd   = 1'b1;
            bus.ioctl_addr = 25'(addr2);
            tick();
            bus.ioctl_rd = 1'b0;
        end
        drain();
    endtask

    task automatic download_range(input int first, input int last, input string name);
        model_size = 0;
        bus.ioctl_download = 1'b1;
        for (int a = first; a <= last; a++) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(a);
            tick();
            if (a + 1 > model_size) model_size = (a + 1 > MAXSZ) ? MAXSZ : a + 1;
        end
        bus.ioctl_wr = 1'b0;
        tick();
        bus.ioctl_download = 1'b0;
        tick();
        check(name, int'(bus.img_size), model_size);
    endtask

    // Host drops upload (or reset hits) two cycles into an in-range fetch.
    task automatic abort_rd(input int addr, input bit use_reset);
        exp_t e;
        e.din = use_reset ? 0 : last_din; e.wlen = 2; e.nrd = 1; e.addr = addr;
        q.push_back(e);
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = 25'(addr);
        tick();
        bus.ioctl_rd = 1'b0;
        tick();
        if (use_reset) reset = 1'b1; else bus.ioctl_upload = 1'b0;
        tick();
        check(use_reset ? "rst_abort_wait" : "up_abort_wait", int'(bus.ioctl_wait), 0);
        check(use_reset ? "rst_abort_busy" : "up_abort_busy", int'(bus.busy), 0);
        if (use_reset) begin
            check("rst_abort_size", int'(bus.img_size), 0);
            check("rst_abort_din", int'(bus.ioctl_din), 0);
            model_size = 0;
            last_din   = 0;
        end
        reset = 1'b0;
        bus.ioctl_upload = 1'b1;
        drain();
    endtask

    initial begin
        for (int i = 0; i < MAXSZ; i++) ram[i] = 8'($urandom);
        ram[16'h0010] = 8'hA5;
        for (int i = 0; i < RD_LAT; i++) begin pd[i] = 8'h00; pv[i] = 1'b0; end
        bus.ioctl_download = 1'b0;
        bus.ioctl_upload   = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_rd       = 1'b0;
        bus.ioctl_addr     = '0;
        model_size = 0;
        last_din   = 0;

        reset = 1'b1;
        repeat (3) tick();
        check("rst_din",      int'(bus.ioctl_din),  0);
        check("rst_wait",     int'(bus.ioctl_wait), 0);
        check("rst_mem_rd",   int'(bus.mem_rd),     0);
        check("rst_mem_addr", int'(bus.mem_addr),   0);
        check("rst_img_size", int'(bus.img_size),   0);
        check("rst_busy",     int'(bus.busy),       0);
        reset = 1'b0;
        tick();

        // No image yet: everything reads as FILL.
        bus.ioctl_upload = 1'b1;
        issue_rd(16'h0010, 1'b0, 0);

        download_range(0, 16'h1FFF, "size_8k");
        issue_rd(16'h0010, 1'b0, 0);
        download_range(0, 15, "size_16");
        issue_rd(15, 1'b0, 0);
        issue_rd(16, 1'b0, 0);

        download_range(16'h00FF, 16'h00FF, "size_100");
        issue_rd(16'h0100, 1'b0, 0);
        issue_rd(16'h00FF, 1'b0, 0);

        // Second request one cycle later is dropped.
        issue_rd(16'h0020, 1'b1, 16'h0030);
        issue_rd(16'h0200, 1'b1, 16'h0030);

        download_range(16'h9000, 16'h9000, "size_sat");
        download_range(25'h1FFFFFF, 25'h1FFFFFF, "size_sat_max");
        issue_rd(16'h7FFF, 1'b0, 0);
        issue_rd(16'h8000, 1'b0, 0);

        // Read strobe during a download: ignored, size still tracked.
        bus.ioctl_download = 1'b1;
        bus.ioctl_wr       = 1'b1;
        bus.ioctl_rd       = 1'b1;
        bus.ioctl_addr     = 25'd5;
        tick();
        bus.ioctl_wr = 1'b0;
        bus.ioctl_rd = 1'b0;
        tick();
        bus.ioctl_download = 1'b0;
        model_size = 6;
        drain();
        check("size_dl_rd", int'(bus.img_size), 6);

        // Read strobe without upload: ignored.
        bus.ioctl_upload = 1'b0;
        bus.ioctl_rd     = 1'b1;
        bus.ioctl_addr   = 25'd2;
        tick();
        bus.ioctl_rd = 1'b0;
        bus.ioctl_upload = 1'b1;
        drain();
        check("noupload_din", int'(bus.ioctl_din), last_din);

        download_range(0, 16'h03FF, "size_400");
        issue_rd(16'h0123, 1'b0, 0);
        abort_rd(16'h0044, 1'b0);
        abort_rd(16'h0045, 1'b1);

        for (int r = 0; r < 3; r++) begin
            int n;
            n = int'($urandom_range(1, 600));
            download_range(0, n - 1, "size_rand");
            for (int k = 0; k < 15; k++) begin
                int kind;
                kind = int'($urandom_range(0, 9));
                if (kind == 0) begin
                    bus.ioctl_upload = 1'b0;
                    bus.ioctl_rd     = 1'b1;
                    bus.ioctl_addr   = 25'($urandom_range(0, n));
                    tick();
                    bus.ioctl_rd     = 1'b0;
                    bus.ioctl_upload = 1'b1;
                    drain();
                end else if (kind == 2) begin
                    issue_rd(int'($urandom_range(MAXSZ, 25'h1FFFFFF)), 1'b0, 0);
                end else begin
                    issue_rd(int'($urandom_range(0, n + 30)), kind == 1,
                             int'($urandom_range(0, n)));
                end
            end
        end

        check("final_mem_rd_residual", rdcnt, 0);
        check("final_queue", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
